// File: rtl/fetch_stage.sv
// fetch_stage: PC register and IF/ID pipeline register for a 32-bit in-order core
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   stall               : hold PC and IF/ID contents
//   redirect/redirect_pc: flush IF/ID and load a new word-aligned PC
//   imem_addr/imem_inst : combinational instruction memory port
//   ifid_*              : registered IF/ID contents
//   misalign_err        : sticky, set by a redirect target with nonzero low bits
//   fetch_count         : count of valid instructions captured into IF/ID
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_inst,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);
   logic [31:0] r_pc;
   logic        r_valid;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc4;
   logic [31:0] r_ifid_inst;
   logic        r_misalign;
   logic [31:0] r_count;
   logic [31:0] w_pc4;
   assign w_pc4 = r_pc + 32'd4;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_valid     <= 1'b0;
         r_ifid_pc   <= '0;
         r_ifid_pc4  <= '0;
         r_ifid_inst <= NOP_INST;
         r_misalign  <= 1'b0;
         r_count     <= '0;
      end else if (redirect) begin
         // flush wins over stall; ifid_pc/pc4 and the count are left untouched
         r_pc        <= {redirect_pc[31:2], 2'b00};
         r_valid     <= 1'b0;
         r_ifid_inst <= NOP_INST;
         if (|redirect_pc[1:0]) r_misalign <= 1'b1;
      end else if (!stall) begin
         r_pc        <= w_pc4;
         r_valid     <= 1'b1;
         r_ifid_pc   <= r_pc;
         r_ifid_pc4  <= w_pc4;
         r_ifid_inst <= imem_inst;
         r_count     <= r_count + 32'd1;
      end
   end
   assign imem_addr    = r_pc;
   assign ifid_valid   = r_valid;
   assign ifid_pc      = r_ifid_pc;
   assign ifid_pc4     = r_ifid_pc4;
   assign ifid_inst    = r_ifid_inst;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_inst;
   logic        misalign_err;
   logic [31:0] fetch_count;
   int checks = 0;
   int failures = 0;
   fetch_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
      .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
      .ifid_inst(ifid_inst), .misalign_err(misalign_err), .fetch_count(fetch_count)
   );
   always #5 clk = ~clk;
   assign imem_inst = 32'hC0DE_0000 | {16'h0000, imem_addr[15:0]};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      step();
      step();
      rst = 1'b0;
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(ifid_valid), 32'h0);
      chk("rst_inst", ifid_inst, 32'h13);
      chk("rst_pc", ifid_pc, 32'h0);
      chk("rst_pc4", ifid_pc4, 32'h0);
      chk("rst_cnt", fetch_count, 32'h0);
      chk("rst_mis", 32'(misalign_err), 32'h0);
      step();
      chk("f1_addr", imem_addr, 32'h4);
      chk("f1_pc", ifid_pc, 32'h0);
      chk("f1_pc4", ifid_pc4, 32'h4);
      chk("f1_inst", ifid_inst, 32'hC0DE_0000);
      chk("f1_valid", 32'(ifid_valid), 32'h1);
      chk("f1_cnt", fetch_count, 32'h1);
      step();
      chk("f2_addr", imem_addr, 32'h8);
      chk("f2_pc", ifid_pc, 32'h4);
      chk("f2_inst", ifid_inst, 32'hC0DE_0004);
      stall = 1'b1;
      step();
      step();
      chk("st_addr", imem_addr, 32'h8);
      chk("st_pc", ifid_pc, 32'h4);
      chk("st_inst", ifid_inst, 32'hC0DE_0004);
      chk("st_cnt", fetch_count, 32'h2);
      stall = 1'b0;
      step();
      chk("f3_addr", imem_addr, 32'hC);
      chk("f3_pc", ifid_pc, 32'h8);
      chk("f3_inst", ifid_inst, 32'hC0DE_0008);
      chk("f3_cnt", fetch_count, 32'h3);
      redirect = 1'b1;
      redirect_pc = 32'h40;
      stall = 1'b1;
      step();
      chk("rs_addr", imem_addr, 32'h40);
      chk("rs_valid", 32'(ifid_valid), 32'h0);
      chk("rs_inst", ifid_inst, 32'h13);
      chk("rs_pc", ifid_pc, 32'h8);
      chk("rs_pc4", ifid_pc4, 32'hC);
      chk("rs_cnt", fetch_count, 32'h3);
      redirect = 1'b0;
      stall = 1'b0;
      step();
      chk("ra_pc", ifid_pc, 32'h40);
      chk("ra_valid", 32'(ifid_valid), 32'h1);
      chk("ra_inst", ifid_inst, 32'hC0DE_0040);
      chk("ra_cnt", fetch_count, 32'h4);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect_pc = 32'h200;
      step();
      chk("bb_addr", imem_addr, 32'h200);
      chk("bb_valid", 32'(ifid_valid), 32'h0);
      chk("bb_cnt", fetch_count, 32'h4);
      redirect = 1'b0;
      step();
      chk("bb2_pc", ifid_pc, 32'h200);
      chk("bb2_valid", 32'(ifid_valid), 32'h1);
      chk("bb2_cnt", fetch_count, 32'h5);
      redirect = 1'b1;
      redirect_pc = 32'h42;
      step();
      chk("mis_addr", imem_addr, 32'h40);
      chk("mis_set", 32'(misalign_err), 32'h1);
      redirect = 1'b0;
      repeat (10) step();
      chk("mis_hold", 32'(misalign_err), 32'h1);
      chk("mis_pc", ifid_pc, 32'h64);
      chk("mis_addr2", imem_addr, 32'h68);
      chk("mis_cnt", fetch_count, 32'd15);
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      redirect = 1'b0;
      step();
      chk("wr_pc", ifid_pc, 32'hFFFF_FFFC);
      chk("wr_pc4", ifid_pc4, 32'h0);
      chk("wr_inst", ifid_inst, 32'hC0DE_FFFC);
      chk("wr_addr2", imem_addr, 32'h0);
      step();
      chk("wr_addr3", imem_addr, 32'h4);
      chk("wr_pc2", ifid_pc, 32'h0);
      chk("wr_cnt", fetch_count, 32'd17);
      rst = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h80;
      stall = 1'b1;
      step();
      chk("rr_addr", imem_addr, 32'h0);
      chk("rr_valid", 32'(ifid_valid), 32'h0);
      chk("rr_mis", 32'(misalign_err), 32'h0);
      chk("rr_cnt", fetch_count, 32'h0);
      chk("rr_inst", ifid_inst, 32'h13);
      chk("rr_pc", ifid_pc, 32'h0);
      rst = 1'b0;
      redirect = 1'b0;
      stall = 1'b0;
      step();
      chk("pr_pc", ifid_pc, 32'h0);
      chk("pr_valid", 32'(ifid_valid), 32'h1);
      chk("pr_cnt", fetch_count, 32'h1);
      chk("pr_addr", imem_addr, 32'h4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
